// File: rtl/acs_unit_k3.sv
// ---------------------------------------------------------------------------
// acs_unit_k3
//   Add-compare-select stage of a rate-1/2, K=3 (generators 7,5 octal),
//   4-state hard-decision Viterbi decoder.  Each accepted step takes one
//   received 2-bit symbol and does the following:
//     - forms the Hamming branch metric for every trellis branch;
//     - adds it to the predecessor path metric, saturating at 2**PM_W-1;
//     - keeps the smaller of the two candidates for each state;
//     - subtracts the minimum new metric so that one metric is always 0.
//   It reports one survivor decision bit per state to the traceback stage.
//
//   Handshake (both sides use strict valid/ready):
//     A symbol transfers on a rising clk edge where sym_valid & sym_ready.
//     A result transfers on a rising clk edge where dec_valid & dec_ready.
//     sym_ready is combinational: it is high when rst_n is high, start is
//     low, and the output register is empty or is being drained this cycle.
//     This lets the stage take one step per cycle under full throughput.
//     While a result is stalled, every output holds and no step fires.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       synchronous reset, active low
//   start       in   1       one-cycle frame restart (reload initial metrics)
//   sym_valid   in   1       sym_in is valid
//   sym_in      in   2       received symbol {g0_bit, g1_bit}
//   sym_ready   out  1       a step can be accepted this cycle
//   dec_valid   out  1       dec_bits/best_state/pm_out hold a new result
//   dec_ready   in   1       downstream accepts the result
//   dec_bits    out  4       bit n = 1: state n survivor came from p1
//   best_state  out  2       lowest index whose normalised metric is 0
//   pm_out      out  4*PM_W  {pm3,pm2,pm1,pm0}, registered path metrics
// ---------------------------------------------------------------------------
module acs_unit_k3 #(
  parameter int PM_W    = 8,
  parameter int PM_INIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sym_valid,
  input  logic [1:0]        sym_in,
  output logic              sym_ready,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        dec_bits,
  output logic [1:0]        best_state,
  output logic [4*PM_W-1:0] pm_out
);

  localparam logic [PM_W-1:0] PM_MAX    = '1;
  localparam logic [PM_W-1:0] PM_INIT_V = PM_W'(PM_INIT);

  // -------------------------------------------------------------------------
  // Branch metric: Hamming distance between the received symbol and the
  // encoder output for predecessor p = {s1,s0} driven by input bit u.
  // -------------------------------------------------------------------------
  function automatic logic [2:0] branch_metric(input logic [1:0] p,
                                               input logic       u,
                                               input logic [1:0] sym);
    logic [1:0] expected;
    logic [1:0] diff;
    expected = {u ^ p[1] ^ p[0], u ^ p[0]};
    diff     = sym ^ expected;
    return {2'b00, diff[1]} + {2'b00, diff[0]};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0][PM_W-1:0] pm_q;
  logic [3:0][PM_W-1:0] pm_d;
  logic                 dec_valid_q;
  logic [3:0]           dec_bits_q;
  logic [3:0]           dec_bits_d;
  logic [1:0]           best_state_q;
  logic [1:0]           best_state_d;

  logic                 fire;

  assign sym_ready = rst_n & ~start & (~dec_valid_q | dec_ready);
  assign fire      = sym_valid & sym_ready;

  // -------------------------------------------------------------------------
  // ACS butterflies.  For next state ns = {u,s1} the two predecessors share
  // s1 = ns[0] and differ in the oldest bit: p0 = {ns[0],0}, p1 = {ns[0],1}.
  // The sum is one bit wider than a metric so saturation is exact.
  // -------------------------------------------------------------------------
  logic [3:0][PM_W-1:0] acs_pm;

  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam int   P0 = (g % 2) * 2;
    localparam int   P1 = P0 + 1;
    localparam logic U  = 1'(g / 2);

    logic [2:0]      bm0;
    logic [2:0]      bm1;
    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign bm0   = branch_metric(2'(P0), U, sym_in);
    assign bm1   = branch_metric(2'(P1), U, sym_in);
    assign sum0  = {1'b0, pm_q[P0]} + (PM_W+1)'(bm0);
    assign sum1  = {1'b0, pm_q[P1]} + (PM_W+1)'(bm1);
    assign cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
    assign cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];

    // Strict compare: a tie keeps p0 and reports decision 0.
    assign dec_bits_d[g] = (cand1 < cand0);
    assign acs_pm[g]     = dec_bits_d[g] ? cand1 : cand0;
  end

  // -------------------------------------------------------------------------
  // Normalisation: subtract the minimum of the four survivors.  Every
  // survivor is >= the minimum, so the subtraction never underflows.
  // -------------------------------------------------------------------------
  logic [PM_W-1:0] min01;
  logic [PM_W-1:0] min23;
  logic [PM_W-1:0] min_all;

  assign min01   = (acs_pm[1] < acs_pm[0]) ? acs_pm[1] : acs_pm[0];
  assign min23   = (acs_pm[3] < acs_pm[2]) ? acs_pm[3] : acs_pm[2];
  assign min_all = (min23 < min01) ? min23 : min01;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pm_d[i] = acs_pm[i] - min_all;
    end
  end

  // Lowest index holding the minimum, i.e. the lowest normalised zero.
  always_comb begin
    best_state_d = 2'd3;
    if (acs_pm[0] == min_all) begin
      best_state_d = 2'd0;
    end else if (acs_pm[1] == min_all) begin
      best_state_d = 2'd1;
    end else if (acs_pm[2] == min_all) begin
      best_state_d = 2'd2;
    end
  end

  // -------------------------------------------------------------------------
  // Registers.  Reset and start share one path.  Start outranks a fire
  // because sym_ready is low during start, and it drops any pending result.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      pm_q[0]      <= '0;
      pm_q[1]      <= PM_INIT_V;
      pm_q[2]      <= PM_INIT_V;
      pm_q[3]      <= PM_INIT_V;
      dec_valid_q  <= 1'b0;
      dec_bits_q   <= 4'b0000;
      best_state_q <= 2'd0;
    end else if (fire) begin
      pm_q         <= pm_d;
      dec_valid_q  <= 1'b1;
      dec_bits_q   <= dec_bits_d;
      best_state_q <= best_state_d;
    end else if (dec_ready) begin
      dec_valid_q  <= 1'b0;
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_bits   = dec_bits_q;
  assign best_state = best_state_q;
  assign pm_out     = pm_q;

endmodule
